// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at issue; results land in HI/LO on the final busy cycle.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        istart,
    input  logic [2:0]  iop,
    input  logic [31:0] iA1,
    input  logic [31:0] iA2,
    output logic        obusy,
    output logic [31:0] ohi,
    output logic [31:0] olo
);

    localparam int unsigned CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [1:0]    op_q;
    logic [31:0]   hi;
    logic [31:0]   lo;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic        div_zero;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        sdiv     = (op_q == 2'd2);
        div_zero = (b_q == '0);
        dvd      = (sdiv && a_q[31]) ? -a_q : a_q;
        dvs      = (sdiv && b_q[31]) ? -b_q : b_q;
        if (div_zero) begin
            dvs = 32'd1;
        end
        quo_mag  = dvd / dvs;
        rem_mag  = dvd % dvs;
        quo      = (sdiv && (a_q[31] ^ b_q[31])) ? -quo_mag : quo_mag;
        rem      = (sdiv && a_q[31]) ? -rem_mag : rem_mag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istart) begin
                        if (!iop[2]) begin
                            a_q   <= iA1;
                            b_q   <= iA2;
                            op_q  <= iop[1:0];
                            cnt   <= iop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= RUN;
                        end else if (iop == OP_MTHI) begin
                            hi <= iA1;
                        end else if (iop == OP_MTLO) begin
                            lo <= iA1;
                        end
                    end
                end
                default: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        if (!op_q[1]) begin
                            {hi, lo} <= op_q[0] ? prod_u : prod_s;
                        end else if (!div_zero) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
            endcase
        end
    end

    assign obusy = (state == RUN);
    assign ohi   = hi;
    assign olo   = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares on every falling edge of obusy.
module tb_mdu_hilo;

    logic        clk;
    logic        reset_n;
    logic        istart;
    logic [2:0]  iop;
    logic [31:0] iA1;
    logic [31:0] iA2;
    logic        obusy;
    logic [31:0] ohi;
    logic [31:0] olo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t sb[$];

    mdu_hilo #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .istart (istart),
        .iop    (iop),
        .iA1    (iA1),
        .iA2    (iA2),
        .obusy  (obusy),
        .ohi    (ohi),
        .olo    (olo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is aligned to a falling edge; the issue edge is the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        istart = 1'b1;
        iop    = o;
        iA1    = a;
        iA2    = b;
        @(negedge clk);
        istart = 1'b0;
        iop    = 3'd7;
    endtask

    task automatic expect_op(input string name, input logic [31:0] h, input logic [31:0] l,
                             input int unsigned cyc);
        exp_t e;
        e.name   = name;
        e.hi     = h;
        e.lo     = l;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (obusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (obusy) begin
            checks++;
            errors++;
            $display("FAIL %s: obusy still high after %0d cycles, required low", name, n);
        end
    endtask

    // Monitor: counts busy cycles and scores each completion.
    initial begin : monitor
        logic busy_prev;
        int unsigned cyc;
        exp_t e;
        busy_prev = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                busy_prev = 1'b0;
                cyc = 0;
            end else begin
                if (obusy) cyc++;
                if (busy_prev && !obusy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got hi=0x%08h lo=0x%08h, required none", ohi, olo);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_busy_cycles"}, cyc, e.cycles);
                        check({e.name, "_hi"}, ohi, e.hi);
                        check({e.name, "_lo"}, olo, e.lo);
                    end
                    cyc = 0;
                end
                busy_prev = obusy;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset_n = 1'b0;
        istart  = 1'b0;
        iop     = 3'd7;
        iA1     = '0;
        iA2     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, obusy}, 32'd0);
        check("reset_hi", ohi, 32'd0);
        check("reset_lo", olo, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        expect_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle("mult_neg");

        expect_op("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle("multu");

        expect_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div_m7_2");

        expect_op("divu_7_2", 32'h0000_0001, 32'h0000_0003, 10);
        issue(3'd3, 32'd7, 32'd2);
        wait_idle("divu_7_2");

        expect_op("div_min_m1", 32'h0000_0000, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_min_m1");

        expect_op("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle("div_7_m2");

        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_hi", ohi, 32'h1234_5678);
        check("mthi_lo_unchanged", olo, 32'hFFFF_FFFD);
        check("mthi_busy", {31'd0, obusy}, 32'd0);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", olo, 32'h9ABC_DEF0);
        check("mtlo_hi_kept", ohi, 32'h1234_5678);
        check("mtlo_busy", {31'd0, obusy}, 32'd0);

        // Protocol violation during RUN: the MTLO and operand changes must be ignored.
        expect_op("mult_3_4_ignored", 32'h0000_0000, 32'h0000_000C, 5);
        issue(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        issue(3'd5, 32'h0000_DEAD, 32'd7);
        iA1 = 32'h5555_5555;
        iA2 = 32'h7777_7777;
        wait_idle("mult_3_4_ignored");

        issue(3'd4, 32'h0000_AAAA, 32'd0);
        issue(3'd5, 32'h0000_BBBB, 32'd0);
        expect_op("divu_by_zero", 32'h0000_AAAA, 32'h0000_BBBB, 10);
        issue(3'd3, 32'd5, 32'd0);
        wait_idle("divu_by_zero");
        expect_op("multu_back2back", 32'h0000_0000, 32'h0000_0004, 5);
        issue(3'd1, 32'd2, 32'd2);
        wait_idle("multu_back2back");

        // Abort a divide with an asynchronous reset pulse between clock edges.
        issue(3'd4, 32'h0000_1111, 32'd0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, obusy}, 32'd0);
        check("abort_hi", ohi, 32'd0);
        check("abort_lo", olo, 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("post_abort_busy", {31'd0, obusy}, 32'd0);
        check("post_abort_hi", ohi, 32'd0);
        check("post_abort_lo", olo, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in EX beside the combinational ALU and takes the same forwarded operand pair.
- Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and holds busy meanwhile. The hazard unit uses busy to stall later HI/LO-touching instructions.
- MTHI/MTLO write HI/LO directly; HI/LO are read combinationally for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- istart  input  1  issue strobe for the operation on iop, one cycle.
- iop  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- iA1  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
- iA2  input  32  rt operand (multiplier/divisor).
- obusy  output  1  high while a MULT/DIV is in flight.
- ohi  output  32  current HI register.
- olo  output  32  current LO register.

Behaviour:
- Reset: asynchronous and active-low. While reset_n=0: HI=0, LO=0, obusy=0, state=IDLE, counter=0, operand latches cleared. Asserting reset mid-operation aborts the operation; no result is written.
- States: IDLE and RUN. obusy = (state==RUN). obusy is registered; it is not combinational from istart.
- IDLE, istart=1 with iop in 0..3:
  - Latch iA1, iA2 and iop at the edge.
  - Go to RUN with counter loaded with MULT_CYCLES or DIV_CYCLES.
- IDLE, istart=1 with iop=4: HI<=iA1 at the edge. With iop=5: LO<=iA1 at the edge. No busy in either case.
- IDLE, istart=1 with iop 6/7: ignored.
- RUN:
  - Counter decrements every cycle.
  - On the edge where counter==1: write HI/LO from the latched operands and return to IDLE.
  - obusy is therefore high for exactly N cycles after the issue edge.
  - The new HI/LO are visible on the same edge that obusy falls.
- istart while RUN: ignored entirely, including MTHI/MTLO. The hazard unit must stall, so this is a protocol violation. The bench checks that it causes no corruption.
- Operand changes on iA1/iA2 during RUN have no effect; results use the latched values.
- MULT: {HI,LO} = signed(A1) × signed(A2), 64-bit two's complement.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (iA2==0 for DIV/DIVU): runs the full DIV_CYCLES with obusy asserted; HI and LO are left unchanged.
- Arithmetic may be computed combinationally from the latched operands and registered at completion. A sequential algorithm is also allowed, provided the latency and results above hold exactly.
- Back-to-back operations: istart in the first cycle after obusy falls is accepted normally.

Test Plan:
- Reset → ohi=olo=0, obusy=0. Then pulse reset_n low during RUN of a DIV → obusy=0 and HI/LO=0 immediately, asynchronously.
- MULT 0xFFFFFFFE × 0x00000003 → obusy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 → LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → ohi/olo update one edge after each; obusy never rises.
- Start MULT 3×4, then during RUN pulse istart with MTLO 0xDEAD and change iA1/iA2 → both ignored. Final HI=0, LO=12.
- DIVU 5 / 0 with preset HI=0xAAAA, LO=0xBBBB → 10 busy cycles, then HI/LO unchanged. Immediately issue MULTU 2×2 on the next cycle → accepted, LO=4.
